// File: rtl/cc_resolve.sv
// Condition-flag resolve at EX/MEM: forwards MEM flags to predicated EX, stalls on load-zero hazard.
// cond_pass/cc_stall/nxt_* are combinational; the MEM slot and wb_* update one cycle after EX.
module cc_resolve #(
  parameter int REG_W    = 3,
  parameter bit LOAD_STL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [1:0]       ex_cond,
  input  logic             ex_sets_c,
  input  logic             ex_sets_z,
  input  logic             ex_is_load,
  input  logic             ex_carry_res,
  input  logic             ex_zero_res,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_zero_load,
  input  logic             cc_carry,
  input  logic             cc_zero,
  output logic             cond_pass,
  output logic             cc_stall,
  output logic             nxt_carry,
  output logic             nxt_zero,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd
);

  logic             m_v, m_sc, m_sz, m_ld, m_c, m_z;
  logic [REG_W-1:0] m_rd;
  logic             eff_c, eff_z, haz, pred;

  always_comb begin
    eff_c = cc_carry;
    eff_z = cc_zero;
    pred  = 1'b1;
    if (m_v && m_sc) eff_c = m_c;
    // A load's zero only exists once the data is back in MEM.
    if (m_v && m_sz) eff_z = m_ld ? mem_zero_load : m_z;
    haz = LOAD_STL & m_v & m_sz & m_ld & ex_valid & (ex_cond == 2'b01);
    case (ex_cond)
      2'b10:   pred = eff_c;
      2'b01:   pred = eff_z;
      default: pred = 1'b1;
    endcase
    cond_pass = reset & ex_valid & ~flush & ~haz & pred;
    cc_stall  = reset & haz & ~stall_in;
    nxt_carry = eff_c;
    nxt_zero  = eff_z;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_v   <= 1'b0;
      m_sc  <= 1'b0;
      m_sz  <= 1'b0;
      m_ld  <= 1'b0;
      m_c   <= 1'b0;
      m_z   <= 1'b0;
      m_rd  <= '0;
      wb_en <= 1'b0;
      wb_rd <= '0;
    end else if (stall_in) begin
      m_v <= m_v;
    end else if (flush || haz || !ex_valid) begin
      m_v   <= 1'b0;
      m_sc  <= 1'b0;
      m_sz  <= 1'b0;
      m_ld  <= 1'b0;
      wb_en <= 1'b0;
    end else begin
      // A failed predicate still occupies MEM but writes nothing.
      m_v   <= 1'b1;
      m_sc  <= ex_sets_c & cond_pass;
      m_sz  <= ex_sets_z & cond_pass;
      m_ld  <= ex_is_load;
      m_c   <= ex_carry_res;
      m_z   <= ex_zero_res;
      m_rd  <= ex_rd;
      wb_en <= cond_pass;
      wb_rd <= ex_rd;
    end
  end

endmodule

// File: tb/tb_cc_resolve.sv
// Directed bench for cc_resolve: stalling (LOAD_STL=1) and forwarding (LOAD_STL=0) instances share stimulus.
module tb_cc_resolve;
  logic       clk = 1'b0;
  logic       reset, stall_in, flush, ex_valid;
  logic [1:0] ex_cond;
  logic       ex_sets_c, ex_sets_z, ex_is_load, ex_carry_res, ex_zero_res;
  logic [2:0] ex_rd;
  logic       mem_zero_load, cc_carry, cc_zero;
  logic       cond_pass, cc_stall, nxt_carry, nxt_zero, wb_en;
  logic [2:0] wb_rd;
  logic       f_pass, f_stall, f_carry, f_zero, f_wb_en;
  logic [2:0] f_wb_rd;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cc_resolve #(.REG_W(3), .LOAD_STL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid),
    .ex_cond(ex_cond), .ex_sets_c(ex_sets_c), .ex_sets_z(ex_sets_z), .ex_is_load(ex_is_load),
    .ex_carry_res(ex_carry_res), .ex_zero_res(ex_zero_res), .ex_rd(ex_rd),
    .mem_zero_load(mem_zero_load), .cc_carry(cc_carry), .cc_zero(cc_zero),
    .cond_pass(cond_pass), .cc_stall(cc_stall), .nxt_carry(nxt_carry), .nxt_zero(nxt_zero),
    .wb_en(wb_en), .wb_rd(wb_rd));

  cc_resolve #(.REG_W(3), .LOAD_STL(1'b0)) u_dut_fwd (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid),
    .ex_cond(ex_cond), .ex_sets_c(ex_sets_c), .ex_sets_z(ex_sets_z), .ex_is_load(ex_is_load),
    .ex_carry_res(ex_carry_res), .ex_zero_res(ex_zero_res), .ex_rd(ex_rd),
    .mem_zero_load(mem_zero_load), .cc_carry(cc_carry), .cc_zero(cc_zero),
    .cond_pass(f_pass), .cc_stall(f_stall), .nxt_carry(f_carry), .nxt_zero(f_zero),
    .wb_en(f_wb_en), .wb_rd(f_wb_rd));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [1:0] cnd, input logic sc, input logic sz,
                          input logic ld, input logic cr, input logic zr, input logic [2:0] rd);
    ex_valid = v; ex_cond = cnd; ex_sets_c = sc; ex_sets_z = sz;
    ex_is_load = ld; ex_carry_res = cr; ex_zero_res = zr; ex_rd = rd;
  endtask

  task automatic idle(input int n);
    drive_ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    flush = 1'b0; stall_in = 1'b0; mem_zero_load = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    drive_ex(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5);
    cc_carry = 1'b1; cc_zero = 1'b0;
    #1;
    checks++; if (cond_pass !== 1'b0) begin failures++; $display("FAIL rst_pass got=%b exp=0", cond_pass); end
    checks++; if (cc_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", cc_stall); end
    checks++; if (wb_en !== 1'b0 || wb_rd !== 3'd0) begin failures++; $display("FAIL rst_wb got=%b/%0d exp=0/0", wb_en, wb_rd); end
    checks++; if (nxt_carry !== 1'b1 || nxt_zero !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=10", nxt_carry, nxt_zero); end
    drive_ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_carry_fwd();
    cc_carry = 1'b0; cc_zero = 1'b0;
    drive_ex(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    #1;
    checks++; if (cond_pass !== 1'b1) begin failures++; $display("FAIL fwd_add_pass got=%b exp=1", cond_pass); end
    cyc();
    drive_ex(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    #1;
    checks++; if (cond_pass !== 1'b1) begin failures++; $display("FAIL fwd_adc_pass got=%b exp=1", cond_pass); end
    checks++; if (nxt_carry !== 1'b1) begin failures++; $display("FAIL fwd_nxt_carry got=%b exp=1", nxt_carry); end
    checks++; if (wb_en !== 1'b1 || wb_rd !== 3'd1) begin failures++; $display("FAIL fwd_wb_add got=%b/%0d exp=1/1", wb_en, wb_rd); end
    cyc();
    checks++; if (wb_en !== 1'b1 || wb_rd !== 3'd2) begin failures++; $display("FAIL fwd_wb_adc got=%b/%0d exp=1/2", wb_en, wb_rd); end
    idle(2);
  endtask

  task automatic test_zero_fail();
    cc_carry = 1'b0; cc_zero = 1'b1;
    drive_ex(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    cyc();
    drive_ex(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    #1;
    checks++; if (cond_pass !== 1'b0) begin failures++; $display("FAIL zf_pass got=%b exp=0", cond_pass); end
    checks++; if (nxt_zero !== 1'b0) begin failures++; $display("FAIL zf_nxt_zero got=%b exp=0", nxt_zero); end
    cyc();
    cc_zero = 1'b0;
    drive_ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL zf_wb_en got=%b exp=0", wb_en); end
    checks++; if (nxt_zero !== 1'b0) begin failures++; $display("FAIL zf_flags_after got=%b exp=0", nxt_zero); end
    idle(2);
  endtask

  task automatic test_load_hazard();
    cc_carry = 1'b0; cc_zero = 1'b0;
    drive_ex(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    cyc();
    mem_zero_load = 1'b1;
    drive_ex(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6);
    #1;
    checks++; if (cc_stall !== 1'b1 || cond_pass !== 1'b0) begin failures++; $display("FAIL lh_stall got=%b/%b exp=1/0", cc_stall, cond_pass); end
    checks++; if (f_stall !== 1'b0 || f_pass !== 1'b1) begin failures++; $display("FAIL lh_fwd got=%b/%b exp=0/1", f_stall, f_pass); end
    checks++; if (nxt_zero !== 1'b1) begin failures++; $display("FAIL lh_nxt_zero got=%b exp=1", nxt_zero); end
    cyc();
    cc_zero = 1'b1; mem_zero_load = 1'b0;
    #1;
    checks++; if (cc_stall !== 1'b0 || cond_pass !== 1'b1) begin failures++; $display("FAIL lh_release got=%b/%b exp=0/1", cc_stall, cond_pass); end
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL lh_bubble_wb got=%b exp=0", wb_en); end
    checks++; if (f_wb_en !== 1'b1 || f_wb_rd !== 3'd6) begin failures++; $display("FAIL lh_fwd_wb got=%b/%0d exp=1/6", f_wb_en, f_wb_rd); end
    cyc();
    checks++; if (wb_en !== 1'b1 || wb_rd !== 3'd6) begin failures++; $display("FAIL lh_adz_wb got=%b/%0d exp=1/6", wb_en, wb_rd); end
    idle(2);
  endtask

  task automatic test_flush_haz();
    cc_carry = 1'b0; cc_zero = 1'b0;
    drive_ex(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    cyc();
    mem_zero_load = 1'b1; stall_in = 1'b1;
    drive_ex(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    #1;
    checks++; if (cc_stall !== 1'b0) begin failures++; $display("FAIL fh_frozen_stall got=%b exp=0", cc_stall); end
    stall_in = 1'b0; flush = 1'b1;
    #1;
    checks++; if (cc_stall !== 1'b1 || cond_pass !== 1'b0) begin failures++; $display("FAIL fh_flush_haz got=%b/%b exp=1/0", cc_stall, cond_pass); end
    checks++; if (wb_en !== 1'b1 || wb_rd !== 3'd2) begin failures++; $display("FAIL fh_lw_wb got=%b/%0d exp=1/2", wb_en, wb_rd); end
    cyc();
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL fh_bubble got=%b exp=0", wb_en); end
    idle(2);
  endtask

  task automatic test_failed_adc();
    cc_carry = 1'b0; cc_zero = 1'b0;
    drive_ex(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
    #1;
    checks++; if (cond_pass !== 1'b0 || nxt_carry !== 1'b0) begin failures++; $display("FAIL fa_ex got=%b/%b exp=0/0", cond_pass, nxt_carry); end
    cyc();
    drive_ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    checks++; if (nxt_carry !== 1'b0 || wb_en !== 1'b0) begin failures++; $display("FAIL fa_mem got=%b/%b exp=0/0", nxt_carry, wb_en); end
    cyc();
    checks++; if (nxt_carry !== 1'b0) begin failures++; $display("FAIL fa_after got=%b exp=0", nxt_carry); end
    idle(1);
  endtask

  task automatic test_stall_hold();
    cc_carry = 1'b0; cc_zero = 1'b0;
    drive_ex(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
    cyc();
    stall_in = 1'b1;
    drive_ex(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (nxt_carry !== 1'b1 || wb_en !== 1'b1 || wb_rd !== 3'd2) begin
        failures++; $display("FAIL sh_hold_%0d got=%b/%b/%0d exp=1/1/2", i, nxt_carry, wb_en, wb_rd);
      end
      cyc();
    end
    stall_in = 1'b0;
    cyc();
    checks++; if (nxt_carry !== 1'b0 || wb_rd !== 3'd3) begin failures++; $display("FAIL sh_advance got=%b/%0d exp=0/3", nxt_carry, wb_rd); end
    idle(2);
  endtask

  task automatic test_reset_mid_hazard();
    cc_carry = 1'b0; cc_zero = 1'b0;
    drive_ex(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
    cyc();
    mem_zero_load = 1'b1;
    drive_ex(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    #1;
    checks++; if (cc_stall !== 1'b1) begin failures++; $display("FAIL rm_pre_stall got=%b exp=1", cc_stall); end
    reset = 1'b0;
    #1;
    checks++; if (cc_stall !== 1'b0 || wb_en !== 1'b0 || cond_pass !== 1'b0) begin
      failures++; $display("FAIL rm_in_reset got=%b/%b/%b exp=0/0/0", cc_stall, wb_en, cond_pass);
    end
    drive_ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    cc_carry = 1'b1; cc_zero = 1'b1; mem_zero_load = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (nxt_carry !== 1'b1 || nxt_zero !== 1'b1) begin failures++; $display("FAIL rm_release got=%b%b exp=11", nxt_carry, nxt_zero); end
    cyc();
    drive_ex(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    #1;
    checks++; if (cc_stall !== 1'b0 || cond_pass !== 1'b1) begin failures++; $display("FAIL rm_after got=%b/%b exp=0/1", cc_stall, cond_pass); end
    idle(2);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; stall_in = 1'b0; flush = 1'b0; mem_zero_load = 1'b0;
    cc_carry = 1'b0; cc_zero = 1'b0;
    drive_ex(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    test_reset();
    #10 reset = 1'b1;
    cyc();
    test_carry_fwd();
    test_zero_fail();
    test_load_hazard();
    test_flush_haz();
    test_failed_adc();
    test_stall_hold();
    test_reset_mid_hazard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
